// File: rtl/onn_phase_pkg.sv
// Shared constants and result type for the ONN multi-channel phase calculator.
package onn_phase_pkg;

    localparam logic MODE_LAG  = 1'b0;
    localparam logic MODE_SYM  = 1'b1;
    localparam int   CNT_W_DEF = 16;
    localparam int   CH_W_DEF  = 2;

    typedef struct packed {
        logic [CH_W_DEF-1:0]  ch;
        logic [CNT_W_DEF-1:0] phi;
        logic [CNT_W_DEF-1:0] period;
    } phase_res_t;

endpackage

// File: rtl/phase_edge_sync.sv
// Synchroniser chain plus rising-edge detector for one oscillator input.
module phase_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/phase_calculator_mc.sv
// Multi-channel phase detector: timestamps channel edges against a reference
// oscillator and streams per-channel phase results round-robin.
module phase_calculator_mc
    import onn_phase_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int CNT_W       = CNT_W_DEF,
    parameter  int SYNC_STAGES = 2,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             n_ref,
    input  logic [N_CH-1:0]  n_in,
    input  logic             mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CH_W-1:0]  res_ch,
    output logic [CNT_W-1:0] res_phi,
    output logic [CNT_W-1:0] res_period,
    output logic [N_CH-1:0]  overrun,
    output logic             ref_lost
);

    localparam logic [CNT_W-1:0] AGE_MAX = '1;

    logic [CNT_W-1:0] ts;
    logic [CNT_W-1:0] ref_ts;
    logic [CNT_W-1:0] ref_period;
    logic [CNT_W-1:0] age;
    logic             ref_seen;
    logic             period_ok;
    logic             ref_pulse;
    logic [N_CH-1:0]  ch_pulse;

    logic [CNT_W-1:0] slot [N_CH];
    logic [N_CH-1:0]  pend;
    logic [CH_W-1:0]  last_q;
    logic [CH_W-1:0]  gnt_idx;
    logic [CH_W-1:0]  rr_idx;
    logic [N_CH-1:0]  gnt_vec;
    logic             gnt_any;
    logic             load;
    logic             take_edge;
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] phi;

    phase_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ref_sync (
        .clk  (clk),
        .reset(reset),
        .din  (n_ref),
        .pulse(ref_pulse)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch_sync
        phase_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .reset(reset),
            .din  (n_in[i]),
            .pulse(ch_pulse[i])
        );
    end

    // A reference edge in the same cycle counts as phase zero.
    always_comb begin
        d   = ts - (ref_pulse ? ts : ref_ts);
        phi = d;
        if (mode == MODE_SYM && period_ok && d > (ref_period >> 1))
            phi = ref_period - d;
    end

    assign take_edge = ref_seen && !ref_lost;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ts         <= '0;
            ref_ts     <= '0;
            ref_period <= '0;
            age        <= '0;
            ref_seen   <= 1'b0;
            period_ok  <= 1'b0;
            ref_lost   <= 1'b0;
        end else begin
            ts <= ts + CNT_W'(1);
            if (ref_pulse) begin
                if (ref_seen) begin
                    ref_period <= ts - ref_ts;
                    period_ok  <= 1'b1;
                end
                ref_ts   <= ts;
                ref_seen <= 1'b1;
                age      <= '0;
                ref_lost <= 1'b0;
            end else if (age != AGE_MAX) begin
                age <= age + CNT_W'(1);
                if (age == AGE_MAX - CNT_W'(1)) begin
                    ref_lost  <= 1'b1;
                    ref_seen  <= 1'b0;
                    period_ok <= 1'b0;
                end
            end
        end
    end

    // Round-robin search begins just after the last granted channel.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_idx  = '0;
        for (int i = 1; i <= N_CH; i++) begin
            rr_idx = CH_W'((int'(last_q) + i) % N_CH);
            if (!gnt_any && pend[rr_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx;
            end
        end
    end

    assign load = gnt_any && (!res_valid || res_ready);

    always_comb begin
        gnt_vec          = '0;
        gnt_vec[gnt_idx] = load;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++)
            if (ch_pulse[i] && take_edge)
                slot[i] <= phi;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend    <= '0;
            overrun <= '0;
            last_q  <= CH_W'(N_CH - 1);
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_pulse[i] && take_edge) begin
                    pend[i] <= 1'b1;
                    if (pend[i] && !gnt_vec[i])
                        overrun[i] <= 1'b1;
                end else if (gnt_vec[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            if (load)
                last_q <= gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            res_valid  <= 1'b0;
            res_ch     <= '0;
            res_phi    <= '0;
            res_period <= '0;
        end else if (load) begin
            res_valid  <= 1'b1;
            res_ch     <= gnt_idx;
            res_phi    <= slot[gnt_idx];
            res_period <= period_ok ? ref_period : '0;
        end else if (res_ready) begin
            res_valid  <= 1'b0;
        end
    end

endmodule
